cic_interp_filter: RTL and testbench
====================================

Name: cic_interp_filter

Overview:
- 3-stage CIC interpolation filter (N=3, M=1). It is the transmit-side counterpart of the team's cic_filter decimator.
- Accepts one low-rate sample every R = 2^os_sel clk cycles and produces one full-rate sample every clk cycle.
- Gain is normalised to 1, so the decimator and this block can be chained back-to-back in loopback benches.
- Single clock domain: the block generates its own input-rate strobe, so no clk_div input is needed.

Parameters:
- DW, 16: signed sample width of data_in and data_out.
- N, 3: number of comb and integrator stages. Fixed; the RTL need not support other values.
- RLOG_MAX, 7: maximum log2(R), matching the 3-bit os_sel.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- os_sel  input  3  rate select; R = 2^os_sel, range 1..128.
- data_in  input  DW  signed low-rate sample; sampled on cycles where in_strobe=1.
- in_strobe  output  1  one-cycle pulse requesting and sampling data_in.
- data_out  output  DW  signed full-rate interpolated sample.
- out_valid  output  1  high once the pipeline has filled.

Behaviour:
- Reset values:
  - rate counter cnt=0, all comb and integrator registers 0, stuffer register 0.
  - data_out=0, out_valid=0, in_strobe=0 while reset=1.
- Internal width: W = DW + N*RLOG_MAX = 37 bits, two's complement. Wrap-around arithmetic is intended and is exact because the final result fits in DW.
- Rate counter:
  - cnt counts 0..R-1 and wraps to 0.
  - in_strobe = (cnt==0) && !reset, so the first strobe occurs in the first cycle after reset deasserts.
  - With os_sel=0, in_strobe is high every cycle.
- Comb section (low rate, enabled only when in_strobe=1):
  - c0 = sign-extended data_in; ck = c(k-1) - dk, for k=1..3.
  - Each delay register dk <= c(k-1) on strobe cycles only.
- Zero-stuffer register up:
  - up <= c3 when in_strobe=1, else up <= 0.
- Integrators (every cycle): i1 <= i1 + up; i2 <= i2 + i1; i3 <= i3 + i2.
- Output stage:
  - data_out <= saturate_DW(i3 >>> (2*os_sel)), arithmetic shift, truncation toward -inf.
  - The shift removes the DC gain R^(N-1).
  - Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
- Latency: a sample taken at strobe edge t first affects data_out after edge t+4.
- out_valid:
  - Goes high 4 cycles after the first strobe following reset or flush.
  - Stays high until the next reset or flush.
- os_sel change:
  - Registered copy os_q. If os_sel != os_q on a cycle, the next edge performs a flush.
  - A flush is identical to reset except that os_q <= os_sel.
  - The first new strobe occurs in the cycle after the flush.
- Reset mid-operation: takes effect at the next edge regardless of counter phase. All partially accumulated state is discarded.
- data_in outside strobe cycles is ignored.

Test Plan:
- Identity path: os_sel=0; data_in=100, then 200, then -50 on consecutive cycles -> out_valid rises 4 cycles after the first strobe; data_out = 100, 200, -50 with 4-cycle latency.
- Impulse response: os_sel=1; data_in=1000 on one strobe, 0 otherwise -> data_out sequence 250, 750, 750, 250, then 0, starting 4 cycles after the impulse strobe.
- DC step: os_sel=3; constant data_in=400 -> data_out ramps monotonically and settles at exactly 400 (check over 64 cycles); in_strobe period is 8 cycles.
- Full-scale extremes: os_sel=7; constant data_in=-32768, then 32767 -> data_out settles to -32768 and 32767 with no wrap glitch; in_strobe period is 128 cycles.
- Rate change: os_sel switched 1->2 mid-stream -> on the next edge, out_valid=0 and data_out=0; strobes resume with period 4; a DC input of 1234 settles back to 1234.
- Mid-operation reset: assert reset for one cycle while cnt!=0 and integrators are non-zero -> all outputs are 0 on the following cycle; the first strobe occurs in the cycle after reset deasserts.

Source files
------------

// File: rtl/cic_interp_filter.sv
// Three-stage CIC interpolator (M=1): low-rate combs, zero-stuffer, full-rate integrators,
// and a gain-normalising arithmetic shift with saturation back to DW bits.
module cic_interp_filter #(
  parameter int DW       = 16,
  parameter int N        = 3,
  parameter int RLOG_MAX = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    os_sel,
  input  logic [DW-1:0] data_in,
  output logic          in_strobe,
  output logic [DW-1:0] data_out,
  output logic          out_valid
);

  localparam int W = DW + N * RLOG_MAX;

  // Clamp a W-bit value into the signed DW range.
  function automatic logic [DW-1:0] sat_dw(input logic signed [W-1:0] v);
    logic [DW-1:0] r;
    if ((&v[W-1:DW-1]) || (~|v[W-1:DW-1])) begin
      r = v[DW-1:0];
    end else if (v[W-1]) begin
      r = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r = {1'b0, {(DW-1){1'b1}}};
    end
    return r;
  endfunction

  logic [6:0]          cnt_q, cnt_d;
  logic [2:0]          os_q;
  logic [2:0]          vcnt_q, vcnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       data_out_q, data_out_d;
  logic signed [W-1:0] d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
  logic signed [W-1:0] up_q, up_d;
  logic signed [W-1:0] i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic signed [W-1:0] c0_s, c1_s, c2_s, c3_s, shifted_s;
  logic [7:0]          r_m1_s;
  logic [3:0]          shamt_s;
  logic                flush_s;

  assign in_strobe = (cnt_q == 7'd0) && !reset;
  assign flush_s   = (os_sel != os_q);
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

  // Next-state logic for the rate counter, combs, integrators and output stage.
  always_comb begin
    r_m1_s    = 8'((8'd1 << os_q) - 8'd1);
    shamt_s   = {os_q, 1'b0};
    c0_s      = {{(W-DW){data_in[DW-1]}}, data_in};
    c1_s      = c0_s - d1_q;
    c2_s      = c1_s - d2_q;
    c3_s      = c2_s - d3_q;
    shifted_s = i3_q >>> shamt_s;

    cnt_d       = cnt_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    up_d        = '0;
    vcnt_d      = vcnt_q;
    i1_d        = i1_q + up_q;
    i2_d        = i2_q + i1_q;
    i3_d        = i3_q + i2_q;
    data_out_d  = sat_dw(shifted_s);
    out_valid_d = out_valid_q | (vcnt_q == 3'd4);

    if ({1'b0, cnt_q} == r_m1_s) begin
      cnt_d = 7'd0;
    end else begin
      cnt_d = cnt_q + 7'd1;
    end

    if (in_strobe) begin
      d1_d = c0_s;
      d2_d = c1_s;
      d3_d = c2_s;
      up_d = c3_s;
    end else begin
      up_d = '0;
    end

    // Fill counter: armed by the first strobe, holds at 4 once the pipeline is full.
    if (vcnt_q == 3'd0) begin
      vcnt_d = in_strobe ? 3'd1 : 3'd0;
    end else if (vcnt_q != 3'd4) begin
      vcnt_d = vcnt_q + 3'd1;
    end else begin
      vcnt_d = vcnt_q;
    end
  end

  // State registers; a rate change flushes exactly like reset while adopting the new rate.
  always_ff @(posedge clk) begin
    if (reset || flush_s) begin
      cnt_q       <= 7'd0;
      os_q        <= os_sel;
      vcnt_q      <= 3'd0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      up_q        <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      os_q        <= os_q;
      vcnt_q      <= vcnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      up_q        <= up_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
    end
  end

endmodule

// File: tb/tb_cic_interp_filter.sv
// Directed bench for cic_interp_filter: a vector table for reset/identity/impulse,
// then hand-written DC, full-scale, rate-change and mid-operation reset sequences.
module tb_cic_interp_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic [2:0]         os_sel;
  logic signed [15:0] data_in;
  logic               in_strobe;
  logic signed [15:0] data_out;
  logic               out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_interp_filter dut (
    .clk       (clk),
    .reset     (reset),
    .os_sel    (os_sel),
    .data_in   (data_in),
    .in_strobe (in_strobe),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  typedef struct {
    logic       rst;
    logic [2:0] os;
    int         din;
    logic       stb;   // in_strobe expected before the edge
    int         dout;  // data_out expected after the edge
    logic       vld;   // out_valid expected after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] o, input int d,
                     input logic s, input int q, input logic v);
    vec_t e;
    e.rst = r; e.os = o; e.din = d; e.stb = s; e.dout = q; e.vld = v;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run ncyc edges; check strobe spacing (period>0) and monotonic direction (dir=+1/-1).
  task automatic run_watch(input int ncyc, input int period, input int dir, input string tag);
    int prev;
    prev = data_out;
    for (int j = 0; j < ncyc; j++) begin
      if (period > 0) check($sformatf("%s strobe[%0d]", tag, j), int'(in_strobe), int'((j % period) == 0));
      step();
      if (dir > 0) check($sformatf("%s rising[%0d]", tag, j), int'(int'(data_out) >= prev), 1);
      else if (dir < 0) check($sformatf("%s falling[%0d]", tag, j), int'(int'(data_out) <= prev), 1);
      prev = data_out;
    end
  endtask

  initial begin
    reset   = 1'b1;
    os_sel  = 3'd0;
    data_in = 16'sd0;

    // Reset, identity path (R=1), then flush to R=2 and an impulse.
    add(1'b1, 3'd0,    0, 1'b0,   0, 1'b0);
    add(1'b1, 3'd0,    0, 1'b0,   0, 1'b0);
    add(1'b0, 3'd0,  100, 1'b1,   0, 1'b0);
    add(1'b0, 3'd0,  200, 1'b1,   0, 1'b0);
    add(1'b0, 3'd0,  -50, 1'b1,   0, 1'b0);
    add(1'b0, 3'd0,    0, 1'b1,   0, 1'b0);
    add(1'b0, 3'd0,    0, 1'b1, 100, 1'b1);
    add(1'b0, 3'd0,    0, 1'b1, 200, 1'b1);
    add(1'b0, 3'd0,    0, 1'b1, -50, 1'b1);
    add(1'b0, 3'd0,    0, 1'b1,   0, 1'b1);
    add(1'b0, 3'd1,    0, 1'b1,   0, 1'b0);
    add(1'b0, 3'd1, 1000, 1'b1,   0, 1'b0);
    add(1'b0, 3'd1,  555, 1'b0,   0, 1'b0);
    add(1'b0, 3'd1,    0, 1'b1,   0, 1'b0);
    add(1'b0, 3'd1,    0, 1'b0,   0, 1'b0);
    add(1'b0, 3'd1,    0, 1'b1, 250, 1'b1);
    add(1'b0, 3'd1,    0, 1'b0, 750, 1'b1);
    add(1'b0, 3'd1,    0, 1'b1, 750, 1'b1);
    add(1'b0, 3'd1,    0, 1'b0, 250, 1'b1);
    add(1'b0, 3'd1,    0, 1'b1,   0, 1'b1);
    add(1'b0, 3'd1,    0, 1'b0,   0, 1'b1);

    for (int k = 0; k < vecs.size(); k++) begin
      reset   = vecs[k].rst;
      os_sel  = vecs[k].os;
      data_in = 16'(vecs[k].din);
      #1;
      check($sformatf("vec%0d strobe", k), int'(in_strobe), int'(vecs[k].stb));
      step();
      check($sformatf("vec%0d data_out", k), int'(data_out), vecs[k].dout);
      check($sformatf("vec%0d out_valid", k), int'(out_valid), int'(vecs[k].vld));
    end

    // DC step at R=8.
    os_sel = 3'd3; data_in = 16'sd400;
    step();
    run_watch(64, 8, 1, "dc8");
    check("dc8 settle", int'(data_out), 400);
    check("dc8 valid", int'(out_valid), 1);

    // Full-scale extremes at R=128.
    os_sel = 3'd7; data_in = -16'sd32768;
    step();
    run_watch(520, 128, -1, "fs_neg");
    check("fs_neg settle", int'(data_out), -32768);
    data_in = 16'sd32767;
    run_watch(520, 0, 1, "fs_pos");
    check("fs_pos settle", int'(data_out), 32767);

    // Rate change 1 -> 2 with DC 1234.
    os_sel = 3'd1; data_in = 16'sd1234;
    step();
    run_watch(40, 2, 1, "dc2");
    check("dc2 settle", int'(data_out), 1234);
    os_sel = 3'd2;
    step();
    check("flush out_valid", int'(out_valid), 0);
    check("flush data_out", int'(data_out), 0);
    check("flush strobe", int'(in_strobe), 1);
    run_watch(64, 4, 1, "dc4");
    check("dc4 settle", int'(data_out), 1234);
    check("dc4 valid", int'(out_valid), 1);

    // Mid-operation reset with the counter off phase.
    step();
    check("pre-reset strobe", int'(in_strobe), 0);
    check("pre-reset data_out", int'(data_out), 1234);
    reset = 1'b1;
    step();
    check("rst data_out", int'(data_out), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst strobe", int'(in_strobe), 0);
    reset = 1'b0;
    #1;
    check("post-reset strobe", int'(in_strobe), 1);
    step();
    check("post-reset data_out", int'(data_out), 0);
    check("post-reset out_valid", int'(out_valid), 0);
    check("post-reset strobe2", int'(in_strobe), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
